// File: rtl/encoder_pkg.sv
// Shared constants and helpers for the registered priority encoder.
// Round-robin priority is enabled by defining RR_PRIORITY_ENCODER_ROUND_ROBIN_EN.
package encoder_pkg;

  localparam int ENC_N_DEFAULT = 32;
  localparam int ENC_PTR_RESET = 0;

  // Index width for n request lines; a 1-bit index is the floor even for n <= 2.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/priority_scan.sv
// Combinational search for the first set request at or above start, wrapping to 0.
// Also reports whether any request is set and whether two or more are set.
module priority_scan #(
  parameter int N = 32,
  parameter int W = 5
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic         any,
  output logic         multi
);

  logic [W-1:0] idx_hi;
  logic [W-1:0] idx_lo;
  logic         found_hi;

  // Descending loops so the last assignment is the lowest qualifying index.
  always_comb begin
    idx_hi   = '0;
    idx_lo   = '0;
    found_hi = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx_lo = W'(i);
        if (i >= int'(start)) begin
          idx_hi   = W'(i);
          found_hi = 1'b1;
        end
      end
    end
  end

  assign idx   = found_hi ? idx_hi : idx_lo;
  assign any   = |req;
  // Clearing the lowest set bit leaves something behind only when two or more bits were set.
  assign multi = |(req & (req - {{(N-1){1'b0}}, 1'b1}));

endmodule

// File: rtl/rr_priority_encoder.sv
// Registered N-to-log2(N) priority encoder with valid/ready output and multi-hot flag.
// Define RR_PRIORITY_ENCODER_ROUND_ROBIN_EN to rotate priority with a ptr register.
module rr_priority_encoder
  import encoder_pkg::*;
#(
  parameter int N = ENC_N_DEFAULT,
  parameter int W = idx_w(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [W-1:0] y,
  output logic         y_valid,
  input  logic         y_ready,
  output logic         y_any,
  output logic         y_multi
);

  // Handshake: a result is transferred on any cycle with y_valid=1 and y_ready=1.
  // While y_valid=1 and y_ready=0 all outputs and ptr hold and req is ignored.
  // A new req is captured when en=1 and the slot is empty or being drained this cycle.
  logic         acc;
  logic [W-1:0] start;
  logic [W-1:0] scan_idx;
  logic         scan_any;
  logic         scan_multi;

  assign acc = en & (~y_valid | y_ready);

  priority_scan #(
    .N(N),
    .W(W)
  ) u_scan (
    .req  (req),
    .start(start),
    .idx  (scan_idx),
    .any  (scan_any),
    .multi(scan_multi)
  );

`ifdef RR_PRIORITY_ENCODER_ROUND_ROBIN_EN
  logic [W-1:0] ptr;

  assign start = ptr;

  // An all-zero accept has no winner, so the rotation point stays put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= W'(ENC_PTR_RESET);
    end else if (acc && scan_any) begin
      ptr <= (scan_idx == W'(N - 1)) ? '0 : scan_idx + 1'b1;
    end
  end
`else
  assign start = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y       <= '0;
      y_valid <= 1'b0;
      y_any   <= 1'b0;
      y_multi <= 1'b0;
    end else if (acc) begin
      y       <= scan_any ? scan_idx : '0;
      y_valid <= 1'b1;
      y_any   <= scan_any;
      y_multi <= scan_multi;
    end else if (y_valid && y_ready) begin
      y_valid <= 1'b0;
    end
  end

endmodule
